uart_echo_core: RTL and testbench
=================================

Name: uart_echo_core

Overview:
Parametrised UART receive/transmit core with an internal receive FIFO and optional hardware echo. It replaces the fixed 9600-baud, 8N1, unbuffered receive/transmit/control chain with one block on the system clock. The baud rate, data width, parity mode and buffer depth are all configurable. Received characters are exposed to user logic and, when echo is enabled, retransmitted in order from the FIFO.

Parameters:
BAUD_DIV, 27, system clocks per 16x oversample tick; bit period = 16*BAUD_DIV clk (27 gives about 115200 baud at 50 MHz); must be >= 2.
DATA_BITS, 8, data bits per frame, 5..8, sent and received LSB first.
PARITY, 0, parity mode: 0 none, 1 odd, 2 even.
FIFO_DEPTH, 16, receive FIFO entries; power of 2, >= 2.

Ports:
clk  in  1  system clock
rst_n  in  1  reset, asynchronous, active-low
rx  in  1  serial input, asynchronous to clk
tx  out  1  serial output
echo_en  in  1  1 = transmitter drains FIFO; 0 = FIFO holds data
rx_data  out  DATA_BITS  last accepted character
rx_valid  out  1  one-clk pulse when rx_data is updated
parity_err  out  1  one-clk pulse, parity mismatch
frame_err  out  1  one-clk pulse, stop bit sampled 0
overflow  out  1  sticky; a character arrived while the FIFO was full
fifo_level  out  clog2(FIFO_DEPTH)+1  current FIFO occupancy
tx_busy  out  1  transmitter not in IDLE

Behaviour:
- Reset (async assert, sync release): tx=1, rx synchroniser=1, both FSMs in IDLE, FIFO empty, all other outputs 0.
- Tick generator: counter 0..BAUD_DIV-1, free-running; tick=1 for one clk when count==BAUD_DIV-1.
- rx path: 2-FF synchroniser; all decisions use the synchronised value.
- RX FSM states: IDLE, START, DATA, PAR, STOP, WAITHI. Each state counts 16 ticks per bit and samples on tick count 7 (mid-bit).
  - IDLE: synchronised rx=0 -> START, reset tick count.
  - START: mid-sample 1 -> IDLE (glitch reject); mid-sample 0 -> DATA.
  - DATA: shift in DATA_BITS samples, LSB first -> PAR if PARITY!=0, else STOP.
  - PAR: sample the parity bit and compare; odd mode requires an odd count of ones over data+parity, even mode an even count.
  - STOP, mid-sample 1, parity ok: clk after the sample, rx_data updated and rx_valid=1 for one clk; character pushed to the FIFO; -> IDLE.
  - STOP, mid-sample 1, parity bad: parity_err pulse, no push, rx_data unchanged, -> IDLE.
  - STOP, mid-sample 0: frame_err pulse, no push, -> WAITHI. Frame error takes priority over parity error (only frame_err pulses).
  - WAITHI: stay until synchronised rx=1, then -> IDLE. No new start is detected while rx is held low.
- FIFO:
  - Push on accepted character. If full, the character is dropped, overflow is set to 1 and stays set until reset; rx_valid still pulses.
  - Simultaneous pop and push when full: both happen, level unchanged, no overflow.
  - When empty, pop is never issued, so a same-cycle push raises level by 1.
  - Read data is taken in the pop cycle.
- TX FSM states: IDLE, START, DATA, PAR, STOP; 16 ticks per bit.
  - IDLE: echo_en=1 and level>0 -> pop, load shifter, start the tick count aligned to the next tick, drive tx=0 from the next clk -> START.
  - Parity bit is generated per PARITY; one stop bit (tx=1); after STOP -> IDLE.
  - Back-to-back characters: the next start bit follows the stop bit with no extra idle.
  - echo_en deasserted mid-frame: the current frame completes; no further pop.
  - tx_busy=1 in every state except IDLE.
- Reset mid-frame: tx=1 immediately, partial characters lost, FIFO cleared, overflow cleared.
- Echo round trip: a character appears on tx no earlier than 1 clk after its rx_valid; rx and tx run fully concurrently.

Test Plan:
1. BAUD_DIV=4, 8N1, echo_en=1, drive 0x55 at 64 clk/bit -> rx_data=0x55, single rx_valid pulse; tx emits start, 1,0,1,0,1,0,1,0, stop, each 64 clk±4; fifo_level returns to 0.
2. PARITY=2, send 0xA3 with parity bit 0 -> accepted and echoed, including parity bit 0. Same data with parity bit 1 -> parity_err pulse, no rx_valid, fifo_level 0, tx stays 1.
3. Frame 0x3C with stop bit 0, then rx held low for 20 bit times -> one frame_err pulse, no push, no further rx_valid. rx released high, then 0x81 sent -> 0x81 received normally.
4. Glitch: rx low for 3*BAUD_DIV clk, then high -> RX stays IDLE, no flags, no rx_valid.
5. FIFO_DEPTH=4, echo_en=0, send 0x01..0x05 -> fifo_level=4, overflow=1, five rx_valid pulses. Then echo_en=1 -> tx emits 0x01,0x02,0x03,0x04 back-to-back, fifo_level=0, overflow stays 1.
6. rst_n pulsed low during tx data bit 3 with FIFO holding 2 entries -> tx=1 and tx_busy=0 asynchronously, fifo_level=0, overflow=0. After release, the next received character echoes correctly.

Source files
------------

// File: rtl/uart_echo_core.sv
// uart_echo_core: UART receiver with a receive FIFO and
// optional in-order hardware echo through the transmitter.
module uart_echo_core #(
  parameter int BAUD_DIV   = 27,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        rx,
  output logic                        tx,
  input  logic                        echo_en,
  output logic [DATA_BITS-1:0]        rx_data,
  output logic                        rx_valid,
  output logic                        parity_err,
  output logic                        frame_err,
  output logic                        overflow,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output logic                        tx_busy
);

  localparam int CW = $clog2(BAUD_DIV);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] DIV_MAX = CW'(BAUD_DIV - 1);
  localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    R_IDLE, R_START, R_DATA, R_PAR, R_STOP, R_WAITHI
  } rx_state_t;

  typedef enum logic [2:0] {
    T_IDLE, T_START, T_DATA, T_PAR, T_STOP
  } tx_state_t;

  logic [CW-1:0] div_cnt;
  logic          tick;
  logic          rx_meta;
  logic          rx_sync;

  rx_state_t            rx_state;
  logic [3:0]           rx_tcnt;
  logic [2:0]           rx_bcnt;
  logic [DATA_BITS-1:0] rx_shift;
  logic                 rx_par_ok;
  logic                 rx_mid;
  logic                 rx_end;

  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr;
  logic [AW-1:0]        rd_ptr;
  logic                 full;
  logic                 push;
  logic                 pop;
  logic                 wr_en;
  logic [DATA_BITS-1:0] rd_data;

  tx_state_t            tx_state;
  logic [3:0]           tx_tcnt;
  logic [2:0]           tx_bcnt;
  logic [DATA_BITS-1:0] tx_shift;
  logic                 tx_par;
  logic                 tx_end;

  assign tick = (div_cnt == DIV_MAX);

  // free-running 16x oversample tick divider
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= tick ? '0 : div_cnt + 1'b1;
    end
  end

  // two-flop synchroniser; idles high like the line
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
    end
  end

  assign rx_mid = tick & (rx_tcnt == 4'd7);
  assign rx_end = tick & (rx_tcnt == 4'd15);

  // receive FSM: mid-bit sampling, flags as 1-clk pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_state   <= R_IDLE;
      rx_tcnt    <= '0;
      rx_bcnt    <= '0;
      rx_shift   <= '0;
      rx_par_ok  <= 1'b0;
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      rx_valid   <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      if (tick && rx_state != R_IDLE && rx_state != R_WAITHI)
        rx_tcnt <= rx_tcnt + 4'd1;
      unique case (rx_state)
        R_IDLE: begin
          if (!rx_sync) begin
            rx_state <= R_START;
            rx_tcnt  <= '0;
          end
        end
        R_START: begin
          if (rx_mid && rx_sync) begin
            rx_state <= R_IDLE;
          end else if (rx_end) begin
            rx_state <= R_DATA;
            rx_bcnt  <= '0;
          end
        end
        R_DATA: begin
          if (rx_mid)
            rx_shift <= {rx_sync, rx_shift[DATA_BITS-1:1]};
          if (rx_end) begin
            if (rx_bcnt == LAST_BIT)
              rx_state <= (PARITY != 0) ? R_PAR : R_STOP;
            else
              rx_bcnt <= rx_bcnt + 3'd1;
          end
        end
        R_PAR: begin
          if (rx_mid)
            rx_par_ok <= (^{rx_sync, rx_shift}) == (PARITY == 1);
          if (rx_end)
            rx_state <= R_STOP;
        end
        R_STOP: begin
          if (rx_mid) begin
            if (!rx_sync) begin
              frame_err <= 1'b1;
              rx_state  <= R_WAITHI;
            end else if (PARITY != 0 && !rx_par_ok) begin
              parity_err <= 1'b1;
              rx_state   <= R_IDLE;
            end else begin
              rx_data  <= rx_shift;
              rx_valid <= 1'b1;
              rx_state <= R_IDLE;
            end
          end
        end
        R_WAITHI: begin
          if (rx_sync)
            rx_state <= R_IDLE;
        end
        default: rx_state <= R_IDLE;
      endcase
    end
  end

  assign full    = fifo_level[AW];
  assign push    = rx_valid;
  assign pop     = (tx_state == T_IDLE) & echo_en & (fifo_level != '0);
  assign wr_en   = push & (~full | pop);
  assign rd_data = mem[rd_ptr];

  // storage array, no reset needed
  always_ff @(posedge clk) begin
    if (wr_en)
      mem[wr_ptr] <= rx_data;
  end

  // FIFO pointers, occupancy and sticky overflow
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
      overflow   <= 1'b0;
    end else begin
      if (wr_en)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      unique case ({wr_en, pop})
        2'b10:   fifo_level <= fifo_level + 1'b1;
        2'b01:   fifo_level <= fifo_level - 1'b1;
        default: fifo_level <= fifo_level;
      endcase
      if (push && full && !pop)
        overflow <= 1'b1;
    end
  end

  assign tx_end = tick & (tx_tcnt == 4'd15);

  // transmit FSM: pops one character per frame
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state <= T_IDLE;
      tx_tcnt  <= '0;
      tx_bcnt  <= '0;
      tx_shift <= '0;
      tx_par   <= 1'b0;
      tx       <= 1'b1;
      tx_busy  <= 1'b0;
    end else begin
      if (tick && tx_state != T_IDLE)
        tx_tcnt <= tx_tcnt + 4'd1;
      unique case (tx_state)
        T_IDLE: begin
          if (pop) begin
            tx_shift <= rd_data;
            tx_par   <= (PARITY == 1) ? ~^rd_data : ^rd_data;
            tx_tcnt  <= '0;
            tx       <= 1'b0;
            tx_busy  <= 1'b1;
            tx_state <= T_START;
          end
        end
        T_START: begin
          if (tx_end) begin
            tx       <= tx_shift[0];
            tx_shift <= {1'b0, tx_shift[DATA_BITS-1:1]};
            tx_bcnt  <= '0;
            tx_state <= T_DATA;
          end
        end
        T_DATA: begin
          if (tx_end) begin
            if (tx_bcnt == LAST_BIT) begin
              if (PARITY != 0) begin
                tx       <= tx_par;
                tx_state <= T_PAR;
              end else begin
                tx       <= 1'b1;
                tx_state <= T_STOP;
              end
            end else begin
              tx       <= tx_shift[0];
              tx_shift <= {1'b0, tx_shift[DATA_BITS-1:1]};
              tx_bcnt  <= tx_bcnt + 3'd1;
            end
          end
        end
        T_PAR: begin
          if (tx_end) begin
            tx       <= 1'b1;
            tx_state <= T_STOP;
          end
        end
        T_STOP: begin
          if (tx_end) begin
            tx_busy  <= 1'b0;
            tx_state <= T_IDLE;
          end
        end
        default: tx_state <= T_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_echo_core.sv
// tb_uart_echo_core: randomized UART frames against a
// queue-based reference model of receive, FIFO and echo.
module tb_uart_echo_core;

  localparam int BD    = 4;
  localparam int BIT   = 16 * BD;
  localparam int DEPTH = 4;
  localparam int FRM   = 11 * BIT;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx = 1'b1;
  logic       echo_en = 1'b0;
  logic       tx;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       parity_err;
  logic       frame_err;
  logic       overflow;
  logic [2:0] fifo_level;
  logic       tx_busy;

  uart_echo_core #(
    .BAUD_DIV(BD), .DATA_BITS(8),
    .PARITY(2), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst_n(rst_n), .rx(rx), .tx(tx),
    .echo_en(echo_en), .rx_data(rx_data),
    .rx_valid(rx_valid), .parity_err(parity_err),
    .frame_err(frame_err), .overflow(overflow),
    .fifo_level(fifo_level), .tx_busy(tx_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] d;
    logic       p;
    logic       st;
    logic       sp;
    int         t0;
  } frame_t;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int pe_cnt = 0;
  int fe_cnt = 0;
  bit tx_ignore = 1'b0;
  bit exp_ovf = 1'b0;

  frame_t     got_tx[$];
  logic [7:0] got_rx[$];
  logic [7:0] exp_rx[$];
  logic [7:0] exp_tx[$];
  logic [7:0] mfifo[$];

  always @(posedge clk) cyc <= cyc + 1;

  // receive-side observer
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (rx_valid === 1'b1) got_rx.push_back(rx_data);
      if (parity_err === 1'b1) pe_cnt++;
      if (frame_err === 1'b1) fe_cnt++;
    end
  end

  // serial decoder for tx, also checks bit-edge timing
  always begin : tx_mon
    frame_t      f;
    logic        prev;
    logic [10:0] s;
    do @(negedge clk);
    while (!(tx === 1'b0 && rst_n === 1'b1));
    f.t0 = cyc;
    prev = 1'b0;
    s = '0;
    for (int k = 1; k <= 10 * BIT + BIT / 2; k++) begin
      @(negedge clk);
      if (tx !== prev) begin
        if (!tx_ignore && rst_n === 1'b1) begin
          checks++;
          if ((k % BIT) > 4 && (k % BIT) < BIT - 4) begin
            errors++;
            $display("FAIL tx_edge at offset %0d, need within 4 of n*%0d",
                     k, BIT);
          end
        end
        prev = tx;
      end
      if (k % BIT == BIT / 2) s[k / BIT] = tx;
    end
    f.st = s[0];
    f.d  = s[8:1];
    f.p  = s[9];
    f.sp = s[10];
    if (!tx_ignore) got_tx.push_back(f);
  end

  function automatic logic even_par(input logic [7:0] d);
    return ($countones(d) % 2) != 0;
  endfunction

  function automatic frame_t frame_at(input int i);
    frame_t f;
    f.d = 'x; f.p = 'x; f.st = 'x; f.sp = 'x; f.t0 = -1;
    if (i < got_tx.size()) f = got_tx[i];
    return f;
  endfunction

  function automatic logic [7:0] rx_at(input int i);
    logic [7:0] v;
    v = 'x;
    if (i < got_rx.size()) v = got_rx[i];
    return v;
  endfunction

  task automatic flush();
    got_rx.delete();
    got_tx.delete();
    exp_rx.delete();
    exp_tx.delete();
  endtask

  task automatic bit_out(input logic v);
    rx = v;
    repeat (BIT) @(negedge clk);
  endtask

  // drive one 8E1 frame and update the reference model
  task automatic send(input logic [7:0] d, input bit bad_par,
                      input bit stop_v);
    bit_out(1'b0);
    for (int i = 0; i < 8; i++) bit_out(d[i]);
    bit_out(even_par(d) ^ bad_par);
    bit_out(stop_v);
    if (stop_v && !bad_par) begin
      exp_rx.push_back(d);
      if (echo_en) exp_tx.push_back(d);
      else if (mfifo.size() < DEPTH) mfifo.push_back(d);
      else exp_ovf = 1'b1;
    end
  endtask

  task automatic wait_tx(input int n, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (got_tx.size() >= n) break;
      @(negedge clk);
    end
    if (got_tx.size() >= n) ok = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    rx = 1'b1;
    echo_en = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (tx !== 1'b1) begin
      errors++; $display("FAIL reset_tx got %b need 1", tx);
    end
    checks++;
    if (tx_busy !== 1'b0) begin
      errors++; $display("FAIL reset_busy got %b need 0", tx_busy);
    end
    checks++;
    if (fifo_level !== 3'd0) begin
      errors++; $display("FAIL reset_level got %0d need 0", fifo_level);
    end
    checks++;
    if (overflow !== 1'b0) begin
      errors++; $display("FAIL reset_ovf got %b need 0", overflow);
    end
    checks++;
    if ({rx_valid, parity_err, frame_err} !== 3'b000) begin
      errors++;
      $display("FAIL reset_flags got %b need 000",
               {rx_valid, parity_err, frame_err});
    end
    checks++;
    if (rx_data !== 8'h00) begin
      errors++; $display("FAIL reset_rx_data got %h need 00", rx_data);
    end
    rst_n = 1'b1;
    repeat (2 * BIT) @(negedge clk);
    checks++;
    if (tx !== 1'b1 || tx_busy !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_idle tx %b busy %b need 1 0", tx, tx_busy);
    end
  endtask

  task automatic test_basic();
    bit ok;
    frame_t f;
    echo_en = 1'b1;
    flush();
    send(8'h55, 1'b0, 1'b1);
    checks++;
    if (got_rx.size() != 1 || rx_at(0) !== 8'h55) begin
      errors++;
      $display("FAIL basic_rx got %0d pulses data %h need 1 pulse 55",
               got_rx.size(), rx_at(0));
    end
    wait_tx(1, 2 * FRM, ok);
    checks++;
    if (!ok) begin
      errors++; $display("FAIL basic_echo_timeout got 0 frames need 1");
    end
    f = frame_at(0);
    checks++;
    if (f.st !== 1'b0 || f.d !== 8'h55 ||
        f.p !== even_par(8'h55) || f.sp !== 1'b1) begin
      errors++;
      $display("FAIL basic_frame got st %b d %h p %b sp %b need 0 55 %b 1",
               f.st, f.d, f.p, f.sp, even_par(8'h55));
    end
    repeat (BIT) @(negedge clk);
    checks++;
    if (fifo_level !== 3'd0 || tx_busy !== 1'b0) begin
      errors++;
      $display("FAIL basic_drain level %0d busy %b need 0 0",
               fifo_level, tx_busy);
    end
  endtask

  task automatic test_parity();
    bit ok;
    int pe0;
    frame_t f;
    echo_en = 1'b1;
    flush();
    pe0 = pe_cnt;
    send(8'hA3, 1'b0, 1'b1);
    send(8'hA3, 1'b1, 1'b1);
    wait_tx(1, 2 * FRM, ok);
    repeat (FRM + BIT) @(negedge clk);
    checks++;
    if (got_rx.size() != 1 || rx_at(0) !== 8'hA3) begin
      errors++;
      $display("FAIL parity_rx got %0d pulses data %h need 1 pulse A3",
               got_rx.size(), rx_at(0));
    end
    checks++;
    if (pe_cnt - pe0 != 1) begin
      errors++;
      $display("FAIL parity_err_pulses got %0d need 1", pe_cnt - pe0);
    end
    f = frame_at(0);
    checks++;
    if (got_tx.size() != 1 || f.d !== 8'hA3 || f.p !== 1'b0) begin
      errors++;
      $display("FAIL parity_echo got %0d frames d %h p %b need 1 A3 0",
               got_tx.size(), f.d, f.p);
    end
    checks++;
    if (fifo_level !== 3'd0 || tx !== 1'b1) begin
      errors++;
      $display("FAIL parity_idle level %0d tx %b need 0 1",
               fifo_level, tx);
    end
  endtask

  task automatic test_random_echo();
    bit ok;
    int pe0, nbad;
    logic [7:0] d;
    bit bad;
    frame_t f;
    echo_en = 1'b1;
    flush();
    pe0 = pe_cnt;
    nbad = 0;
    for (int i = 0; i < 6; i++) begin
      d = 8'($urandom);
      bad = ($urandom_range(0, 3) == 0);
      if (bad) nbad++;
      send(d, bad, 1'b1);
    end
    wait_tx(exp_tx.size(), 3 * FRM, ok);
    repeat (2 * BIT) @(negedge clk);
    checks++;
    if (got_rx.size() != exp_rx.size()) begin
      errors++;
      $display("FAIL rand_rx_count got %0d need %0d",
               got_rx.size(), exp_rx.size());
    end
    for (int i = 0; i < exp_rx.size(); i++) begin
      checks++;
      if (rx_at(i) !== exp_rx[i]) begin
        errors++;
        $display("FAIL rand_rx[%0d] got %h need %h", i, rx_at(i), exp_rx[i]);
      end
    end
    checks++;
    if (got_tx.size() != exp_tx.size()) begin
      errors++;
      $display("FAIL rand_tx_count got %0d need %0d",
               got_tx.size(), exp_tx.size());
    end
    for (int i = 0; i < exp_tx.size(); i++) begin
      f = frame_at(i);
      checks++;
      if (f.st !== 1'b0 || f.d !== exp_tx[i] ||
          f.p !== even_par(exp_tx[i]) || f.sp !== 1'b1) begin
        errors++;
        $display("FAIL rand_tx[%0d] got st %b d %h p %b sp %b need 0 %h %b 1",
                 i, f.st, f.d, f.p, f.sp, exp_tx[i], even_par(exp_tx[i]));
      end
    end
    checks++;
    if (pe_cnt - pe0 != nbad) begin
      errors++;
      $display("FAIL rand_parity_errs got %0d need %0d", pe_cnt - pe0, nbad);
    end
    checks++;
    if (fifo_level !== 3'd0) begin
      errors++; $display("FAIL rand_level got %0d need 0", fifo_level);
    end
  endtask

  task automatic test_frame();
    bit ok;
    int pe0, fe0;
    echo_en = 1'b1;
    flush();
    pe0 = pe_cnt;
    fe0 = fe_cnt;
    send(8'h3C, 1'b1, 1'b0);
    repeat (20 * BIT) @(negedge clk);
    rx = 1'b1;
    repeat (2 * BIT) @(negedge clk);
    checks++;
    if (fe_cnt - fe0 != 1 || pe_cnt != pe0) begin
      errors++;
      $display("FAIL frame_flags got fe %0d pe %0d need 1 0",
               fe_cnt - fe0, pe_cnt - pe0);
    end
    checks++;
    if (got_rx.size() != 0 || fifo_level !== 3'd0 || got_tx.size() != 0) begin
      errors++;
      $display("FAIL frame_no_push got rx %0d level %0d tx %0d need 0 0 0",
               got_rx.size(), fifo_level, got_tx.size());
    end
    send(8'h81, 1'b0, 1'b1);
    wait_tx(1, 2 * FRM, ok);
    checks++;
    if (got_rx.size() != 1 || rx_at(0) !== 8'h81) begin
      errors++;
      $display("FAIL frame_recover_rx got %0d pulses %h need 1 pulse 81",
               got_rx.size(), rx_at(0));
    end
    checks++;
    if (!ok || frame_at(0).d !== 8'h81) begin
      errors++;
      $display("FAIL frame_recover_echo got %h need 81", frame_at(0).d);
    end
  endtask

  task automatic test_glitch();
    int pe0, fe0;
    flush();
    pe0 = pe_cnt;
    fe0 = fe_cnt;
    rx = 1'b0;
    repeat (3 * BD) @(negedge clk);
    rx = 1'b1;
    repeat (FRM + BIT) @(negedge clk);
    checks++;
    if (got_rx.size() != 0 || pe_cnt != pe0 || fe_cnt != fe0 ||
        got_tx.size() != 0) begin
      errors++;
      $display("FAIL glitch got rx %0d pe %0d fe %0d tx %0d need 0 0 0 0",
               got_rx.size(), pe_cnt - pe0, fe_cnt - fe0, got_tx.size());
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    int gap;
    frame_t f;
    echo_en = 1'b0;
    flush();
    mfifo.delete();
    for (int i = 1; i <= 5; i++) send(8'(i), 1'b0, 1'b1);
    repeat (10) @(negedge clk);
    checks++;
    if (got_rx.size() != 5) begin
      errors++; $display("FAIL ovf_rx_pulses got %0d need 5", got_rx.size());
    end
    for (int i = 0; i < exp_rx.size(); i++) begin
      checks++;
      if (rx_at(i) !== exp_rx[i]) begin
        errors++;
        $display("FAIL ovf_rx[%0d] got %h need %h", i, rx_at(i), exp_rx[i]);
      end
    end
    checks++;
    if (fifo_level !== 3'(mfifo.size()) || overflow !== exp_ovf) begin
      errors++;
      $display("FAIL ovf_state got level %0d ovf %b need %0d %b",
               fifo_level, overflow, mfifo.size(), exp_ovf);
    end
    checks++;
    if (got_tx.size() != 0 || tx !== 1'b1) begin
      errors++;
      $display("FAIL ovf_hold got %0d frames need 0", got_tx.size());
    end
    exp_tx = mfifo;
    mfifo.delete();
    echo_en = 1'b1;
    wait_tx(exp_tx.size(), exp_tx.size() * FRM + 4 * BIT, ok);
    repeat (FRM + BIT) @(negedge clk);
    checks++;
    if (got_tx.size() != exp_tx.size()) begin
      errors++;
      $display("FAIL drain_count got %0d need %0d",
               got_tx.size(), exp_tx.size());
    end
    for (int i = 0; i < exp_tx.size(); i++) begin
      f = frame_at(i);
      checks++;
      if (f.d !== exp_tx[i] || f.p !== even_par(exp_tx[i]) ||
          f.sp !== 1'b1) begin
        errors++;
        $display("FAIL drain[%0d] got d %h p %b sp %b need %h %b 1",
                 i, f.d, f.p, f.sp, exp_tx[i], even_par(exp_tx[i]));
      end
      if (i > 0) begin
        gap = f.t0 - frame_at(i - 1).t0;
        checks++;
        if (gap < FRM - 4 || gap > FRM + 4) begin
          errors++;
          $display("FAIL drain_gap[%0d] got %0d clk need %0d +-4",
                   i, gap, FRM);
        end
      end
    end
    checks++;
    if (fifo_level !== 3'd0 || overflow !== exp_ovf) begin
      errors++;
      $display("FAIL drain_state got level %0d ovf %b need 0 %b",
               fifo_level, overflow, exp_ovf);
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    logic [7:0] d;
    echo_en = 1'b0;
    flush();
    for (int i = 0; i < 3; i++) send(8'($urandom), 1'b0, 1'b1);
    repeat (10) @(negedge clk);
    checks++;
    if (fifo_level !== 3'd3 || overflow !== exp_ovf) begin
      errors++;
      $display("FAIL pre_reset got level %0d ovf %b need 3 %b",
               fifo_level, overflow, exp_ovf);
    end
    tx_ignore = 1'b1;
    echo_en = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (tx === 1'b0) break;
      @(negedge clk);
    end
    checks++;
    if (tx !== 1'b0) begin
      errors++; $display("FAIL pre_reset_start got tx %b need 0", tx);
    end
    repeat (4 * BIT + BIT / 2) @(negedge clk);
    checks++;
    if (fifo_level !== 3'd2 || tx_busy !== 1'b1) begin
      errors++;
      $display("FAIL mid_frame got level %0d busy %b need 2 1",
               fifo_level, tx_busy);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (tx !== 1'b1 || tx_busy !== 1'b0) begin
      errors++;
      $display("FAIL async_reset_tx got tx %b busy %b need 1 0",
               tx, tx_busy);
    end
    checks++;
    if (fifo_level !== 3'd0 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL async_reset_fifo got level %0d ovf %b need 0 0",
               fifo_level, overflow);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    mfifo.delete();
    exp_ovf = 1'b0;
    repeat (FRM + BIT) @(negedge clk);
    flush();
    tx_ignore = 1'b0;
    checks++;
    if (tx !== 1'b1 || fifo_level !== 3'd0) begin
      errors++;
      $display("FAIL post_reset got tx %b level %0d need 1 0",
               tx, fifo_level);
    end
    d = 8'($urandom);
    send(d, 1'b0, 1'b1);
    wait_tx(1, 2 * FRM, ok);
    checks++;
    if (!ok || rx_at(0) !== d || frame_at(0).d !== d ||
        frame_at(0).p !== even_par(d)) begin
      errors++;
      $display("FAIL post_reset_echo got rx %h tx %h p %b need %h %h %b",
               rx_at(0), frame_at(0).d, frame_at(0).p, d, d, even_par(d));
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_parity();
    test_random_echo();
    test_frame();
    test_glitch();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
